// File: rtl/mac_vector_engine.sv
`default_nettype none
// ============================================================================
// Module   : mac_vector_engine
// Brief    : Streamed dot-product engine, y = sat(bias + sum(a[i]*b[i])).
// Revision : 1.0
// ============================================================================
module mac_vector_engine #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [OUT_W-1:0]  bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  y,
    output logic              sat,
    output logic              busy
);

    localparam int               c_P_W     = 2 * DATA_W;
    localparam logic [LEN_W-1:0] c_LEN_ONE = LEN_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_acc_next;
    logic [ACC_W-1:0]  w_bias_ext;
    logic [ACC_W-1:0]  w_p_ext;
    logic [c_P_W-1:0]  r_p;
    logic [c_P_W-1:0]  w_prod;
    logic [c_P_W-1:0]  w_a_ext;
    logic [c_P_W-1:0]  w_b_ext;
    logic              r_pv;
    logic              w_beat;
    logic              w_last;
    logic              r_out_valid;
    logic              r_sat;
    logic              w_sat_flag;
    logic [OUT_W-1:0]  r_y;
    logic [OUT_W-1:0]  w_sat_y;
    logic              w_in_ready;
    logic              w_busy;

    // Operands are widened to the product width first so the low 2*DATA_W
    // bits of a plain multiply are correct for either signedness.
    generate
        if (SIGNED != 0) begin : g_signed
            logic [ACC_W-OUT_W:0] w_upper;

            assign w_a_ext    = {{DATA_W{a[DATA_W-1]}}, a};
            assign w_b_ext    = {{DATA_W{b[DATA_W-1]}}, b};
            assign w_bias_ext = {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias};
            assign w_p_ext    = {{(ACC_W-c_P_W){r_p[c_P_W-1]}}, r_p};
            assign w_upper    = w_acc_next[ACC_W-1:OUT_W-1];

            always_comb begin
                w_sat_flag = ~((&w_upper) | (~|w_upper));
                w_sat_y    = w_acc_next[OUT_W-1:0];
                if (w_sat_flag) begin
                    if (w_acc_next[ACC_W-1]) begin
                        w_sat_y = {1'b1, {(OUT_W-1){1'b0}}};
                    end else begin
                        w_sat_y = {1'b0, {(OUT_W-1){1'b1}}};
                    end
                end
            end
        end else begin : g_unsigned
            assign w_a_ext    = {{DATA_W{1'b0}}, a};
            assign w_b_ext    = {{DATA_W{1'b0}}, b};
            assign w_bias_ext = {{(ACC_W-OUT_W){1'b0}}, bias};
            assign w_p_ext    = {{(ACC_W-c_P_W){1'b0}}, r_p};

            always_comb begin
                w_sat_flag = |w_acc_next[ACC_W-1:OUT_W];
                w_sat_y    = w_sat_flag ? {OUT_W{1'b1}} : w_acc_next[OUT_W-1:0];
            end
        end
    endgenerate

    assign w_prod     = w_a_ext * w_b_ext;
    assign w_acc_next = r_acc + (r_pv ? w_p_ext : {ACC_W{1'b0}});
    assign w_beat     = in_valid & w_in_ready;
    assign w_last     = (r_cnt == (r_len - c_LEN_ONE));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_next = (len == '0) ? c_DRAIN : c_ACCUM;
                end
            end
            c_ACCUM: begin
                if (w_beat && w_last) begin
                    w_state_next = c_DRAIN;
                end
            end
            c_DRAIN: begin
                w_state_next = c_DONE;
            end
            c_DONE: begin
                if (out_ready) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // Decoded state outputs
    always_comb begin
        w_in_ready = (r_state == c_ACCUM);
        w_busy     = (r_state != c_IDLE);
    end

    // Datapath: product pipeline, accumulator and held result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len       <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_p         <= '0;
            r_pv        <= 1'b0;
            r_y         <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_len <= len;
                        r_acc <= w_bias_ext;
                        r_cnt <= '0;
                        r_pv  <= 1'b0;
                    end
                end
                c_ACCUM: begin
                    r_acc <= w_acc_next;
                    r_pv  <= w_beat;
                    if (w_beat) begin
                        r_p   <= w_prod;
                        r_cnt <= r_cnt + c_LEN_ONE;
                    end
                end
                c_DRAIN: begin
                    r_acc       <= w_acc_next;
                    r_pv        <= 1'b0;
                    r_y         <= w_sat_y;
                    r_sat       <= w_sat_flag;
                    r_out_valid <= 1'b1;
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_pv <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign busy      = w_busy;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign sat       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_mac_vector_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_vector_engine
// Brief    : Self-checking bench for signed and unsigned mac_vector_engine.
// Revision : 1.0
// ============================================================================
module tb_mac_vector_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_s;
    logic        start_u;
    logic [7:0]  len;
    logic [15:0] bias;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  a;
    logic [7:0]  b;

    logic        in_ready_s, out_valid_s, sat_s, busy_s;
    logic [15:0] y_s;
    logic        in_ready_u, out_valid_u, sat_u, busy_u;
    logic [15:0] y_u;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] op_a[$];
    logic [7:0] op_b[$];

    always #5 clk = ~clk;

    mac_vector_engine #(
        .DATA_W(8), .OUT_W(16), .LEN_W(8), .ACC_W(32), .SIGNED(1)
    ) u_dut_s (
        .clk(clk), .reset_n(reset_n), .start(start_s), .len(len), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b),
        .out_valid(out_valid_s), .out_ready(out_ready), .y(y_s), .sat(sat_s),
        .busy(busy_s)
    );

    mac_vector_engine #(
        .DATA_W(8), .OUT_W(16), .LEN_W(8), .ACC_W(32), .SIGNED(0)
    ) u_dut_u (
        .clk(clk), .reset_n(reset_n), .start(start_u), .len(len), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready_u), .a(a), .b(b),
        .out_valid(out_valid_u), .out_ready(out_ready), .y(y_u), .sat(sat_u),
        .busy(busy_u)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ov(input bit u);
        return u ? out_valid_u : out_valid_s;
    endfunction
    function automatic logic get_rdy(input bit u);
        return u ? in_ready_u : in_ready_s;
    endfunction
    function automatic logic get_busy(input bit u);
        return u ? busy_u : busy_s;
    endfunction
    function automatic logic get_sat(input bit u);
        return u ? sat_u : sat_s;
    endfunction
    function automatic logic [15:0] get_y(input bit u);
        return u ? y_u : y_s;
    endfunction

    // Reference: exact integer dot product, then clamp to the 16-bit range.
    function automatic logic [16:0] model(input bit u, input int l, input logic [15:0] bi);
        longint s;
        logic [15:0] ys;
        logic st;
        s = u ? longint'(bi) : longint'($signed(bi));
        for (int i = 0; i < l; i++) begin
            if (u) s += longint'(op_a[i]) * longint'(op_b[i]);
            else   s += longint'($signed(op_a[i])) * longint'($signed(op_b[i]));
        end
        st = 1'b0;
        ys = s[15:0];
        if (u) begin
            if (s > 65535) begin ys = 16'hFFFF; st = 1'b1; end
        end else begin
            if (s > 32767)       begin ys = 16'h7FFF; st = 1'b1; end
            else if (s < -32768) begin ys = 16'h8000; st = 1'b1; end
        end
        return {st, ys};
    endfunction

    task automatic fill_random(input int l);
        op_a.delete();
        op_b.delete();
        for (int i = 0; i < l; i++) begin
            op_a.push_back(8'($urandom));
            op_b.push_back(8'($urandom));
        end
    endtask

    // Runs one op from IDLE (called at a negedge). Latency is counted in
    // rising edges after the start edge until out_valid is seen: len+1.
    task automatic do_op(input bit u, input int l, input logic [15:0] bi, input int gap,
                         input int hold, input bit poke, input string tag);
        logic [16:0] exp;
        int edges, idx, wg;
        bit acc, rdy_seen;
        exp = model(u, l, bi);
        len = 8'(l);
        bias = bi;
        out_ready = 1'b0;
        in_valid = 1'b0;
        if (u) start_u = 1'b1; else start_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!poke) begin start_u = 1'b0; start_s = 1'b0; end
        len = 8'($urandom);
        bias = 16'($urandom);
        edges = 0; idx = 0; wg = 0; rdy_seen = 1'b0;
        while (!get_ov(u) && edges < 2000) begin
            if (idx < l && wg == 0) begin
                in_valid = 1'b1; a = op_a[idx]; b = op_b[idx];
            end else begin
                in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
            end
            rdy_seen |= get_rdy(u);
            acc = in_valid && get_rdy(u);
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (acc) begin idx++; wg = gap; end
            else if (wg > 0) wg--;
        end
        check({tag, "_out_valid"}, 32'(get_ov(u)), 32'd1);
        check({tag, "_beats"}, idx, l);
        if (gap == 0) check({tag, "_latency"}, edges, l + 1);
        if (l == 0) check({tag, "_ready_seen"}, 32'(rdy_seen), 32'd0);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            check({tag, "_hold_ready"}, 32'(get_rdy(u)), 32'd0);
            check({tag, "_hold_valid"}, 32'(get_ov(u)), 32'd1);
            check({tag, "_hold_y"}, 32'(get_y(u)), 32'(exp[15:0]));
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({tag, "_y"}, 32'(get_y(u)), 32'(exp[15:0]));
        check({tag, "_sat"}, 32'(get_sat(u)), 32'(exp[16]));
        check({tag, "_busy_done"}, 32'(get_busy(u)), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        start_s = 1'b0;
        start_u = 1'b0;
        check({tag, "_valid_drop"}, 32'(get_ov(u)), 32'd0);
        check({tag, "_idle"}, 32'(get_busy(u)), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        bit seen_ov;
        reset_n = 1'b0; start_s = 1'b0; start_u = 1'b0; len = '0; bias = '0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid_s), 32'd0);
        check("rst_ready", 32'(in_ready_s), 32'd0);
        check("rst_busy",  32'(busy_s), 32'd0);
        check("rst_y",     32'(y_s), 32'd0);
        check("rst_sat",   32'(sat_s), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        op_a = '{8'd3, 8'd3, 8'd3, 8'd3};
        op_b = '{8'd4, 8'd4, 8'd4, 8'd4};
        do_op(1'b0, 4, 16'd10, 0, 1, 1'b0, "basic");

        op_a = '{8'd5, 8'd7, 8'hFF};
        op_b = '{8'hFE, 8'd1, 8'hFF};
        do_op(1'b0, 3, 16'd0, 2, 5, 1'b0, "bubbles");

        op_a = '{8'd127, 8'd127, 8'd127, 8'd127};
        op_b = '{8'd127, 8'd127, 8'd127, 8'd127};
        do_op(1'b0, 4, 16'd0, 0, 0, 1'b0, "sat_pos");

        op_a = '{8'h80, 8'h80, 8'h80};
        op_b = '{8'd127, 8'd127, 8'd127};
        do_op(1'b0, 3, 16'd0, 0, 0, 1'b0, "sat_neg");

        op_a.delete();
        op_b.delete();
        do_op(1'b0, 0, 16'hFFFB, 0, 1, 1'b0, "zero_len");

        // Abort an op after three beats; result must never appear.
        len = 8'd8; bias = 16'd100; start_s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s = 1'b0;
        in_valid = 1'b1; a = 8'd9; b = 8'd9;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("abort_ready", 32'(in_ready_s), 32'd0);
        check("abort_busy",  32'(busy_s), 32'd0);
        check("abort_y",     32'(y_s), 32'd0);
        check("abort_sat",   32'(sat_s), 32'd0);
        seen_ov = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            seen_ov |= out_valid_s;
            if (k == 4) reset_n = 1'b1;
        end
        check("abort_no_valid", 32'(seen_ov), 32'd0);
        op_a = '{8'd2};
        op_b = '{8'd2};
        do_op(1'b0, 1, 16'd0, 0, 0, 1'b0, "after_abort");

        op_a = '{8'd255, 8'd255};
        op_b = '{8'd255, 8'd255};
        do_op(1'b1, 2, 16'd0, 0, 3, 1'b1, "uns_sat");

        for (int t = 0; t < 6; t++) begin
            int l;
            l = int'($urandom_range(1, 12));
            fill_random(l);
            do_op(1'b0, l, 16'($urandom), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), 1'($urandom), "rnd_s");
        end
        for (int t = 0; t < 4; t++) begin
            int l;
            l = int'($urandom_range(1, 6));
            fill_random(l);
            for (int i = 0; i < l; i++) op_a[i] = 8'($urandom_range(0, 40));
            do_op(1'b1, l, 16'($urandom_range(0, 2000)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), 1'($urandom), "rnd_u");
        end

        fill_random(255);
        do_op(1'b0, 255, 16'($urandom), 0, 0, 1'b0, "max_len");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
